// File: rtl/soc_mem_arbiter_if.sv
// Bus bundle between two Avalon-MM style masters, the arbiter and the memory s1 port.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface soc_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_lock;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_lock;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        output mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        input  mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/soc_mem_arbiter.sv
// Two-master arbiter for the single-port on-chip memory: combinational grant with
// round-robin or fixed priority, lock hold-over, and 1-cycle read-return routing.
module soc_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    soc_mem_arbiter_if.slave  bus
);
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    master_e prio_ptr;
    master_e lock_owner;
    master_e rd_tag;
    master_e winner;
    logic    lock_valid;
    logic    rd_pend;
    logic    req0;
    logic    req1;
    logic    grant;
    logic    win_read;
    logic    win_write;
    logic    win_lock;

    always_comb begin
        req0   = bus.m0_read | bus.m0_write;
        req1   = bus.m1_read | bus.m1_write;
        winner = M0;
        if (req0 && req1) begin
            if (lock_valid)
                winner = lock_owner;
            else if (RR_EN)
                winner = prio_ptr;
            else
                winner = M0;
        end else if (req1) begin
            winner = M1;
        end
        // Reset suppresses every grant so nothing is accepted while it is high.
        grant = ~reset & (req0 | req1);
    end

    always_comb begin
        win_write = (winner == M1) ? bus.m1_write : bus.m0_write;
        win_read  = ((winner == M1) ? bus.m1_read : bus.m0_read) & ~win_write;
        win_lock  = (winner == M1) ? bus.m1_lock : bus.m0_lock;
    end

    always_comb begin
        bus.mem_address    = (winner == M1) ? bus.m1_address    : bus.m0_address;
        bus.mem_byteenable = (winner == M1) ? bus.m1_byteenable : bus.m0_byteenable;
        bus.mem_writedata  = (winner == M1) ? bus.m1_writedata  : bus.m0_writedata;
        bus.mem_write      = grant & win_write;
        bus.mem_chipselect = grant;
        bus.mem_clken      = 1'b1;

        bus.m0_waitrequest = req0 & ~(grant & (winner == M0));
        bus.m1_waitrequest = req1 & ~(grant & (winner == M1));

        bus.m0_readdata      = bus.mem_readdata;
        bus.m1_readdata      = bus.mem_readdata;
        bus.m0_readdatavalid = rd_pend & (rd_tag == M0);
        bus.m1_readdatavalid = rd_pend & (rd_tag == M1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_ptr   <= M0;
            lock_valid <= 1'b0;
            lock_owner <= M0;
            rd_pend    <= 1'b0;
            rd_tag     <= M0;
        end else if (grant) begin
            prio_ptr   <= (winner == M0) ? M1 : M0;
            lock_valid <= win_lock;
            lock_owner <= winner;
            rd_pend    <= win_read;
            rd_tag     <= winner;
        end else begin
            lock_valid <= 1'b0;
            rd_pend    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter: round-robin instance with a memory model,
// plus a fixed-priority instance for the m0-always-wins case.
module tb_soc_mem_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    soc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus_a ();
    soc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus_b ();

    soc_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RR_EN(1'b1)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    soc_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RR_EN(1'b0)) dut_fixed (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Behavioural 64K x 32 memory with byte lanes and 1-cycle read latency.
    logic [31:0] mem_model [0:65535];
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (bus_a.mem_chipselect && bus_a.mem_clken) begin
            if (bus_a.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus_a.mem_byteenable[b])
                        mem_model[bus_a.mem_address][8*b +: 8] <= bus_a.mem_writedata[8*b +: 8];
            end else begin
                rdata <= mem_model[bus_a.mem_address];
            end
        end
    end
    assign bus_a.mem_readdata = rdata;
    assign bus_b.mem_readdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic lk);
        bus_a.m0_read = rd; bus_a.m0_write = wr; bus_a.m0_address = a;
        bus_a.m0_byteenable = be; bus_a.m0_writedata = d; bus_a.m0_lock = lk;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic lk);
        bus_a.m1_read = rd; bus_a.m1_write = wr; bus_a.m1_address = a;
        bus_a.m1_byteenable = be; bus_a.m1_writedata = d; bus_a.m1_lock = lk;
    endtask

    task automatic drv_b(input logic rd0, input logic rd1);
        bus_b.m0_read = rd0; bus_b.m0_write = 1'b0; bus_b.m0_address = 16'h0001;
        bus_b.m0_byteenable = 4'hF; bus_b.m0_writedata = '0; bus_b.m0_lock = 1'b0;
        bus_b.m1_read = rd1; bus_b.m1_write = 1'b0; bus_b.m1_address = 16'h0002;
        bus_b.m1_byteenable = 4'hF; bus_b.m1_writedata = '0; bus_b.m1_lock = 1'b0;
    endtask

    initial begin
        logic exp_m1;
        logic prev_m1;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drv0(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        drv1(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        drv_b(1'b0, 1'b0);

        // Reset: requests are held off, then no readdatavalid follows
        cyc();
        drv0(1'b1, 1'b0, 16'h0030, 4'hF, 32'h0, 1'b0);
        drv1(1'b1, 1'b0, 16'h0030, 4'hF, 32'h0, 1'b0);
        #1;
        check("rst_cs",      32'(bus_a.mem_chipselect), 32'd0);
        check("rst_m0_wait", 32'(bus_a.m0_waitrequest), 32'd1);
        check("rst_m1_wait", 32'(bus_a.m1_waitrequest), 32'd1);
        check("rst_m0_rdv",  32'(bus_a.m0_readdatavalid), 32'd0);
        cyc();
        reset = 1'b0;
        drv0(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        drv1(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        check("post_rst_m0_rdv", 32'(bus_a.m0_readdatavalid), 32'd0);
        check("post_rst_m1_rdv", 32'(bus_a.m1_readdatavalid), 32'd0);
        check("idle_m0_wait",    32'(bus_a.m0_waitrequest), 32'd0);
        check("idle_cs",         32'(bus_a.mem_chipselect), 32'd0);

        // m0 write then read of the same word
        drv0(1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0);
        #1;
        check("wr_m0_wait", 32'(bus_a.m0_waitrequest), 32'd0);
        check("wr_memwr",   32'(bus_a.mem_write), 32'd1);
        check("wr_cs",      32'(bus_a.mem_chipselect), 32'd1);
        check("wr_addr",    32'(bus_a.mem_address), 32'h10);
        cyc();
        drv0(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);
        #1;
        check("rd_m0_wait",   32'(bus_a.m0_waitrequest), 32'd0);
        check("rd_memwr",     32'(bus_a.mem_write), 32'd0);
        check("wr_no_rdv",    32'(bus_a.m0_readdatavalid), 32'd0);
        cyc();
        drv0(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        check("rd_m0_rdv",  32'(bus_a.m0_readdatavalid), 32'd1);
        check("rd_m0_data", bus_a.m0_readdata, 32'hDEADBEEF);
        check("rd_m1_rdv",  32'(bus_a.m1_readdatavalid), 32'd0);
        cyc();
        check("rdv_clears", 32'(bus_a.m0_readdatavalid), 32'd0);

        // Byte-lane merge
        drv0(1'b0, 1'b1, 16'h0020, 4'hF, 32'h11223344, 1'b0);
        cyc();
        drv0(1'b0, 1'b1, 16'h0020, 4'h1, 32'h000000AA, 1'b0);
        cyc();
        drv0(1'b1, 1'b0, 16'h0020, 4'hF, 32'h0, 1'b0);
        cyc();
        drv0(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        check("be_rdv",  32'(bus_a.m0_readdatavalid), 32'd1);
        check("be_data", bus_a.m0_readdata, 32'h112233AA);

        // Reset pulse, then both read: grants alternate starting with m0
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv0(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);
            drv1(1'b1, 1'b0, 16'h0020, 4'hF, 32'h0, 1'b0);
            #1;
            exp_m1 = (i % 2) == 1;
            check($sformatf("rr%0d_m0_wait", i), 32'(bus_a.m0_waitrequest), 32'(exp_m1));
            check($sformatf("rr%0d_m1_wait", i), 32'(bus_a.m1_waitrequest), 32'(!exp_m1));
            check($sformatf("rr%0d_addr", i), 32'(bus_a.mem_address), exp_m1 ? 32'h20 : 32'h10);
            if (i > 0) begin
                prev_m1 = !exp_m1;
                check($sformatf("rr%0d_m0_rdv", i), 32'(bus_a.m0_readdatavalid), 32'(!prev_m1));
                check($sformatf("rr%0d_m1_rdv", i), 32'(bus_a.m1_readdatavalid), 32'(prev_m1));
                check($sformatf("rr%0d_data", i), bus_a.m0_readdata,
                      prev_m1 ? 32'h112233AA : 32'hDEADBEEF);
            end
            cyc();
        end
        drv0(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        drv1(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        check("rr_last_m1_rdv", 32'(bus_a.m1_readdatavalid), 32'd1);
        check("rr_last_m0_rdv", 32'(bus_a.m0_readdatavalid), 32'd0);
        check("rr_last_data",   bus_a.m1_readdata, 32'h112233AA);

        // Lock: lone m0 read hands priority to m1, then m1 holds the port for 3 writes
        drv0(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0);
        cyc();
        drv1(1'b0, 1'b1, 16'h0040, 4'hF, 32'h000000A0, 1'b1);
        #1;
        check("lk1_m1_wait", 32'(bus_a.m1_waitrequest), 32'd0);
        check("lk1_m0_wait", 32'(bus_a.m0_waitrequest), 32'd1);
        check("lk1_m0_rdv",  32'(bus_a.m0_readdatavalid), 32'd1);
        cyc();
        drv1(1'b0, 1'b1, 16'h0041, 4'hF, 32'h000000A1, 1'b1);
        #1;
        check("lk2_m1_wait", 32'(bus_a.m1_waitrequest), 32'd0);
        check("lk2_m0_wait", 32'(bus_a.m0_waitrequest), 32'd1);
        cyc();
        drv1(1'b0, 1'b1, 16'h0042, 4'hF, 32'h000000A2, 1'b0);
        #1;
        check("lk3_m1_wait", 32'(bus_a.m1_waitrequest), 32'd0);
        check("lk3_m0_wait", 32'(bus_a.m0_waitrequest), 32'd1);
        check("lk3_addr",    32'(bus_a.mem_address), 32'h42);
        cyc();
        drv1(1'b1, 1'b0, 16'h0042, 4'hF, 32'h0, 1'b0);
        #1;
        check("unlk_m0_wait", 32'(bus_a.m0_waitrequest), 32'd0);
        check("unlk_m1_wait", 32'(bus_a.m1_waitrequest), 32'd1);
        cyc();
        drv0(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        check("unlk2_m1_wait", 32'(bus_a.m1_waitrequest), 32'd0);
        check("unlk2_m0_rdv",  32'(bus_a.m0_readdatavalid), 32'd1);
        check("unlk2_m0_data", bus_a.m0_readdata, 32'hDEADBEEF);
        cyc();
        drv1(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        check("lk_rb_m1_rdv", 32'(bus_a.m1_readdatavalid), 32'd1);
        check("lk_rb_data",   bus_a.m1_readdata, 32'h000000A2);

        // Fixed priority: m0 wins every contended cycle
        for (int i = 0; i < 4; i++) begin
            drv_b(1'b1, 1'b1);
            #1;
            check($sformatf("fx%0d_m0_wait", i), 32'(bus_b.m0_waitrequest), 32'd0);
            check($sformatf("fx%0d_m1_wait", i), 32'(bus_b.m1_waitrequest), 32'd1);
            cyc();
        end
        drv_b(1'b0, 1'b1);
        #1;
        check("fx_drop_m1_wait", 32'(bus_b.m1_waitrequest), 32'd0);
        check("fx_drop_addr",    32'(bus_b.mem_address), 32'h2);
        cyc();
        drv_b(1'b0, 1'b0);
        #1;
        check("fx_m1_rdv", 32'(bus_b.m1_readdatavalid), 32'd1);
        check("fx_m0_rdv", 32'(bus_b.m0_readdatavalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
